// File: rtl/tube_event_framer.sv
// +--------------------------------------------------------------------------+
// | tube_event_framer: frames raw per-event tube words into header/body/     |
// | trailer records, buffered so downstream backpressure never splits one.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tube_event_framer #(
  parameter int DEPTH         = 64,
  parameter int MAX_BODY      = 32,
  parameter int SUPPRESS_ZERO = 1
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        in_wr_en,
  input  logic [15:0] in_din,
  input  logic        fifo_full,
  input  logic        clr_flags,
  output logic [15:0] out_din,
  output logic        out_wr_en,
  output logic [7:0]  event_num,
  output logic [15:0] drop_cnt,
  output logic        overflow,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]  c_depth    = (AW+1)'(DEPTH);
  localparam logic [AW:0]  c_need     = (AW+1)'(MAX_BODY + 2);
  localparam logic [7:0]   c_max_body = 8'(MAX_BODY);
  localparam logic [15:0]  c_term     = 16'hFFFF;
  localparam logic [7:0]   c_hdr_tag  = 8'hF0;
  localparam logic [7:0]   c_trl_tag  = 8'hF1;

  localparam logic [1:0] c_idle    = 2'd0;
  localparam logic [1:0] c_body    = 2'd1;
  localparam logic [1:0] c_trailer = 2'd2;
  localparam logic [1:0] c_drop    = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [15:0]   r_hold;
  logic          r_hold_valid;
  logic [7:0]    r_body_cnt;
  logic [7:0]    r_hit_cnt;
  logic          r_forced;

  logic          w_is_term;
  logic          w_admit;
  logic          w_pop;
  logic          w_hold_qual;
  logic [AW:0]   w_free;

  logic          w_push;
  logic [15:0]   w_push_data;
  logic          w_hdr;
  logic          w_hold_load;
  logic          w_hold_flush;
  logic          w_hit_inc;
  logic          w_drop;
  logic          w_proto_set;
  logic          w_evt_inc;
  logic          w_force_set;
  logic          w_force_clr;

  assign w_is_term   = (in_din == c_term);
  assign w_free      = c_depth - r_count;
  assign w_admit     = (w_free >= c_need);
  assign w_pop       = (r_count != '0) && !fifo_full;
  assign w_hold_qual = r_hold_valid && ((SUPPRESS_ZERO == 0) || (r_hold[15:8] != 8'd0));

  // State register
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (in_wr_en) begin
          if (!w_admit)
            w_next_state = w_is_term ? c_idle : c_drop;
          else if (w_is_term)
            w_next_state = c_trailer;
          else
            w_next_state = c_body;
        end
      end
      c_body: begin
        if (in_wr_en && (w_is_term || (r_body_cnt == c_max_body)))
          w_next_state = c_trailer;
      end
      c_trailer: begin
        // A forced trailer leaves the rest of the runaway event to be skipped
        if (r_forced && !(in_wr_en && w_is_term))
          w_next_state = c_drop;
        else
          w_next_state = c_idle;
      end
      c_drop: begin
        if (in_wr_en && w_is_term)
          w_next_state = c_idle;
      end
      default: w_next_state = c_idle;
    endcase
  end

  // Output/control logic
  always_comb begin
    w_push       = 1'b0;
    w_push_data  = 16'd0;
    w_hdr        = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_flush = 1'b0;
    w_hit_inc    = 1'b0;
    w_drop       = 1'b0;
    w_proto_set  = 1'b0;
    w_evt_inc    = 1'b0;
    w_force_set  = 1'b0;
    w_force_clr  = 1'b0;
    case (r_state)
      c_idle: begin
        if (in_wr_en) begin
          w_evt_inc = 1'b1;
          if (w_admit) begin
            w_push      = 1'b1;
            w_push_data = {event_num, c_hdr_tag};
            w_hdr       = 1'b1;
            w_hold_load = !w_is_term;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      c_body: begin
        if (in_wr_en) begin
          w_push       = w_hold_qual;
          w_push_data  = r_hold;
          w_hit_inc    = w_hold_qual;
          w_hold_flush = 1'b1;
          if (!w_is_term) begin
            if (r_body_cnt == c_max_body) begin
              w_proto_set = 1'b1;
              w_force_set = 1'b1;
            end else begin
              w_hold_load = 1'b1;
            end
          end
        end
      end
      c_trailer: begin
        w_push      = 1'b1;
        w_push_data = {r_hit_cnt, c_trl_tag};
        w_proto_set = in_wr_en;
        w_force_clr = 1'b1;
      end
      default: ;
    endcase
  end

  // Hold register and per-event counters
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_hold       <= 16'd0;
      r_hold_valid <= 1'b0;
      r_body_cnt   <= 8'd0;
      r_hit_cnt    <= 8'd0;
      r_forced     <= 1'b0;
    end else begin
      if (w_hold_load) begin
        r_hold       <= in_din;
        r_hold_valid <= 1'b1;
      end else if (w_hold_flush) begin
        r_hold_valid <= 1'b0;
      end
      if (w_hdr)
        r_body_cnt <= {7'd0, w_hold_load};
      else if (w_hold_load)
        r_body_cnt <= r_body_cnt + 8'd1;
      if (w_hdr)
        r_hit_cnt <= 8'd0;
      else if (w_hit_inc)
        r_hit_cnt <= r_hit_cnt + 8'd1;
      if (w_force_set)
        r_forced <= 1'b1;
      else if (w_force_clr)
        r_forced <= 1'b0;
    end
  end

  // Event numbering and sticky status; a drop outranks a same-cycle clear
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      event_num <= 8'd0;
      drop_cnt  <= 16'd0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_evt_inc)
        event_num <= event_num + 8'd1;
      if (w_drop) begin
        overflow <= 1'b1;
        if (clr_flags)
          drop_cnt <= 16'd1;
        else if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
        drop_cnt <= 16'd0;
      end
      if (w_proto_set)
        proto_err <= 1'b1;
      else if (clr_flags)
        proto_err <= 1'b0;
    end
  end

  always_ff @(posedge clk100) begin
    if (w_push)
      r_mem[r_wptr] <= w_push_data;
  end

  // Circular buffer pointers, occupancy and registered FIFO write port
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      out_din   <= 16'd0;
      out_wr_en <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 1'b1;
      if (w_pop)
        r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      out_wr_en <= w_pop;
      if (w_pop)
        out_din <= r_mem[r_rptr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tube_event_framer.sv
// Directed bench for tube_event_framer: one instance with zero suppression,
// one without, sharing all inputs.
`default_nettype none

module tb_tube_event_framer;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        in_wr_en;
  logic [15:0] in_din;
  logic        fifo_full;
  logic        clr_flags;

  logic [15:0] out_din_sz, drop_cnt_sz, out_din_nz, drop_cnt_nz;
  logic        out_wr_en_sz, overflow_sz, proto_err_sz;
  logic        out_wr_en_nz, overflow_nz, proto_err_nz;
  logic [7:0]  event_num_sz, event_num_nz;

  int n_checks = 0;
  int n_fail   = 0;
  int bp_viol  = 0;
  logic ff_q;

  logic [15:0] q_sz[$];
  logic [15:0] q_nz[$];
  logic [15:0] e_sz[$];
  logic [15:0] e_nz[$];

  always #5 clk100 = ~clk100;

  tube_event_framer #(.DEPTH(64), .MAX_BODY(32), .SUPPRESS_ZERO(1)) dut_sz (
    .clk100(clk100), .rst(rst), .in_wr_en(in_wr_en), .in_din(in_din),
    .fifo_full(fifo_full), .clr_flags(clr_flags), .out_din(out_din_sz),
    .out_wr_en(out_wr_en_sz), .event_num(event_num_sz), .drop_cnt(drop_cnt_sz),
    .overflow(overflow_sz), .proto_err(proto_err_sz)
  );

  tube_event_framer #(.DEPTH(64), .MAX_BODY(32), .SUPPRESS_ZERO(0)) dut_nz (
    .clk100(clk100), .rst(rst), .in_wr_en(in_wr_en), .in_din(in_din),
    .fifo_full(fifo_full), .clr_flags(clr_flags), .out_din(out_din_nz),
    .out_wr_en(out_wr_en_nz), .event_num(event_num_nz), .drop_cnt(drop_cnt_nz),
    .overflow(overflow_nz), .proto_err(proto_err_nz)
  );

  always @(posedge clk100) ff_q <= fifo_full;

  // Collect every FIFO write; also catch writes issued against a full FIFO
  always @(negedge clk100) begin
    if (out_wr_en_sz) begin
      q_sz.push_back(out_din_sz);
      if (ff_q === 1'b1) bp_viol++;
    end
    if (out_wr_en_nz) begin
      q_nz.push_back(out_din_nz);
      if (ff_q === 1'b1) bp_viol++;
    end
  end

  task automatic send(input logic [15:0] d);
    in_wr_en = 1'b1;
    in_din   = d;
    @(posedge clk100);
    #1;
    in_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic clear_queues;
    q_sz.delete(); q_nz.delete(); e_sz.delete(); e_nz.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_wr_en = 1'b0; in_din = 16'd0; fifo_full = 1'b0; clr_flags = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    n_checks++; if (out_din_sz !== 16'd0) begin n_fail++; $display("FAIL reset_out_din: got %h expected 0000", out_din_sz); end
    n_checks++; if (out_wr_en_sz !== 1'b0) begin n_fail++; $display("FAIL reset_out_wr_en: got %b expected 0", out_wr_en_sz); end
    n_checks++; if (event_num_sz !== 8'd0) begin n_fail++; $display("FAIL reset_event_num: got %h expected 00", event_num_sz); end
    n_checks++; if (drop_cnt_sz !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt_sz); end
    n_checks++; if ({overflow_sz, proto_err_sz} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {overflow_sz, proto_err_sz}); end
    n_checks++;
    if ({out_din_nz, out_wr_en_nz, event_num_nz, drop_cnt_nz, overflow_nz, proto_err_nz} !== 43'd0) begin
      n_fail++; $display("FAIL reset_nz_outputs: got %h expected 0", {out_din_nz, out_wr_en_nz, event_num_nz, drop_cnt_nz, overflow_nz, proto_err_nz});
    end
  endtask

  task automatic test_nominal;
    logic [15:0] w;
    clear_queues();
    e_sz = '{16'h00F0, 16'h12C2, 16'h402F, 16'h02F1};
    e_nz.push_back(16'h00F0);
    for (int i = 0; i < 32; i++) begin
      if (i == 5) w = 16'h12C2;
      else if (i == 20) w = 16'h402F;
      else w = {8'h00, 8'(i)};
      e_nz.push_back(w);
      send(w);
    end
    e_nz.push_back(16'h20F1);
    send(16'hFFFF);
    idle(45);
    n_checks++; if (q_sz.size() != e_sz.size()) begin n_fail++; $display("FAIL nominal_sz_count: got %0d expected %0d", q_sz.size(), e_sz.size()); end
    for (int i = 0; i < e_sz.size() && i < q_sz.size(); i++) begin
      n_checks++; if (q_sz[i] !== e_sz[i]) begin n_fail++; $display("FAIL nominal_sz_word[%0d]: got %h expected %h", i, q_sz[i], e_sz[i]); end
    end
    n_checks++; if (q_nz.size() != e_nz.size()) begin n_fail++; $display("FAIL nominal_nz_count: got %0d expected %0d", q_nz.size(), e_nz.size()); end
    for (int i = 0; i < e_nz.size() && i < q_nz.size(); i++) begin
      n_checks++; if (q_nz[i] !== e_nz[i]) begin n_fail++; $display("FAIL nominal_nz_word[%0d]: got %h expected %h", i, q_nz[i], e_nz[i]); end
    end
    n_checks++; if (event_num_sz !== 8'd1) begin n_fail++; $display("FAIL nominal_event_num: got %h expected 01", event_num_sz); end
  endtask

  task automatic test_no_suppress;
    clear_queues();
    e_sz = '{16'h01F0, 16'h00F1};
    e_nz.push_back(16'h01F0);
    for (int i = 0; i < 32; i++) begin
      e_nz.push_back({8'h00, 8'(i)});
      send({8'h00, 8'(i)});
    end
    e_nz.push_back(16'h20F1);
    send(16'hFFFF);
    idle(45);
    n_checks++; if (q_nz.size() != 34) begin n_fail++; $display("FAIL nosup_nz_count: got %0d expected 34", q_nz.size()); end
    for (int i = 0; i < e_nz.size() && i < q_nz.size(); i++) begin
      n_checks++; if (q_nz[i] !== e_nz[i]) begin n_fail++; $display("FAIL nosup_nz_word[%0d]: got %h expected %h", i, q_nz[i], e_nz[i]); end
    end
    n_checks++; if (q_sz.size() != e_sz.size()) begin n_fail++; $display("FAIL nosup_sz_count: got %0d expected %0d", q_sz.size(), e_sz.size()); end
    for (int i = 0; i < e_sz.size() && i < q_sz.size(); i++) begin
      n_checks++; if (q_sz[i] !== e_sz[i]) begin n_fail++; $display("FAIL nosup_sz_word[%0d]: got %h expected %h", i, q_sz[i], e_sz[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] w;
    clear_queues();
    fifo_full = 1'b1;
    e_sz.push_back(16'h02F0);
    e_nz.push_back(16'h02F0);
    for (int i = 0; i < 32; i++) begin
      w = (i % 4 == 0) ? {8'(i + 1), 8'(i)} : {8'h00, 8'(i)};
      e_nz.push_back(w);
      if (i % 4 == 0) e_sz.push_back(w);
      send(w);
    end
    send(16'hFFFF);
    e_sz.push_back(16'h08F1);
    e_nz.push_back(16'h20F1);
    idle(17);
    n_checks++; if (q_sz.size() + q_nz.size() != 0) begin n_fail++; $display("FAIL bp_writes_while_full: got %0d expected 0", q_sz.size() + q_nz.size()); end
    fifo_full = 1'b0;
    idle(45);
    n_checks++; if (q_sz.size() != e_sz.size()) begin n_fail++; $display("FAIL bp_sz_count: got %0d expected %0d", q_sz.size(), e_sz.size()); end
    for (int i = 0; i < e_sz.size() && i < q_sz.size(); i++) begin
      n_checks++; if (q_sz[i] !== e_sz[i]) begin n_fail++; $display("FAIL bp_sz_word[%0d]: got %h expected %h", i, q_sz[i], e_sz[i]); end
    end
    n_checks++; if (q_nz.size() != e_nz.size()) begin n_fail++; $display("FAIL bp_nz_count: got %0d expected %0d", q_nz.size(), e_nz.size()); end
    for (int i = 0; i < e_nz.size() && i < q_nz.size(); i++) begin
      n_checks++; if (q_nz[i] !== e_nz[i]) begin n_fail++; $display("FAIL bp_nz_word[%0d]: got %h expected %h", i, q_nz[i], e_nz[i]); end
    end
    n_checks++; if ({overflow_sz, overflow_nz} !== 2'b00) begin n_fail++; $display("FAIL bp_overflow: got %b expected 00", {overflow_sz, overflow_nz}); end
    n_checks++; if (bp_viol != 0) begin n_fail++; $display("FAIL bp_write_after_full: got %0d expected 0", bp_viol); end
  endtask

  task automatic test_drop;
    clear_queues();
    fifo_full = 1'b1;
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 32; i++) send({8'h00, 8'(i)});
      send(16'hFFFF);
      idle(2);
      e_sz.push_back({8'(3 + e), 8'hF0});
      e_sz.push_back(16'h00F1);
    end
    e_nz.push_back(16'h03F0);
    for (int i = 0; i < 32; i++) e_nz.push_back({8'h00, 8'(i)});
    e_nz.push_back(16'h20F1);
    n_checks++; if (drop_cnt_nz !== 16'd2) begin n_fail++; $display("FAIL drop_cnt_nz: got %0d expected 2", drop_cnt_nz); end
    n_checks++; if (overflow_nz !== 1'b1) begin n_fail++; $display("FAIL drop_overflow_nz: got %b expected 1", overflow_nz); end
    n_checks++; if ({drop_cnt_sz, overflow_sz} !== 17'd0) begin n_fail++; $display("FAIL drop_sz_no_drop: got %h expected 0", {drop_cnt_sz, overflow_sz}); end
    n_checks++; if (event_num_nz !== 8'd6) begin n_fail++; $display("FAIL drop_event_num: got %0d expected 6", event_num_nz); end
    fifo_full = 1'b0;
    idle(45);
    n_checks++; if (q_nz.size() != e_nz.size()) begin n_fail++; $display("FAIL drop_nz_count: got %0d expected %0d", q_nz.size(), e_nz.size()); end
    for (int i = 0; i < e_nz.size() && i < q_nz.size(); i++) begin
      n_checks++; if (q_nz[i] !== e_nz[i]) begin n_fail++; $display("FAIL drop_nz_word[%0d]: got %h expected %h", i, q_nz[i], e_nz[i]); end
    end
    n_checks++; if (q_sz.size() != e_sz.size()) begin n_fail++; $display("FAIL drop_sz_count: got %0d expected %0d", q_sz.size(), e_sz.size()); end
    for (int i = 0; i < e_sz.size() && i < q_sz.size(); i++) begin
      n_checks++; if (q_sz[i] !== e_sz[i]) begin n_fail++; $display("FAIL drop_sz_word[%0d]: got %h expected %h", i, q_sz[i], e_sz[i]); end
    end
    // Next admitted event: header-then-empty carrying event number 6
    clear_queues();
    send(16'hFFFF);
    idle(6);
    n_checks++; if (q_nz.size() != 2) begin n_fail++; $display("FAIL drop_next_count: got %0d expected 2", q_nz.size()); end
    else begin
      n_checks++; if (q_nz[0] !== 16'h06F0) begin n_fail++; $display("FAIL drop_next_header: got %h expected 06F0", q_nz[0]); end
      n_checks++; if (q_nz[1] !== 16'h00F1) begin n_fail++; $display("FAIL drop_next_trailer: got %h expected 00F1", q_nz[1]); end
    end
    n_checks++; if (bp_viol != 0) begin n_fail++; $display("FAIL drop_write_after_full: got %0d expected 0", bp_viol); end
  endtask

  task automatic test_clr_flags;
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;
    n_checks++; if ({drop_cnt_nz, overflow_nz} !== 17'd0) begin n_fail++; $display("FAIL clr_flags: got %h expected 0", {drop_cnt_nz, overflow_nz}); end
    // Fill the no-suppress buffer, then drop an event while clearing
    fifo_full = 1'b1;
    for (int i = 0; i < 32; i++) send({8'h00, 8'(i)});
    send(16'hFFFF);
    idle(2);
    clr_flags = 1'b1;
    send(16'h0000);
    clr_flags = 1'b0;
    for (int i = 1; i < 32; i++) send({8'h00, 8'(i)});
    send(16'hFFFF);
    idle(2);
    n_checks++; if (drop_cnt_nz !== 16'd1) begin n_fail++; $display("FAIL clr_vs_drop_cnt: got %0d expected 1", drop_cnt_nz); end
    n_checks++; if (overflow_nz !== 1'b1) begin n_fail++; $display("FAIL clr_vs_drop_overflow: got %b expected 1", overflow_nz); end
    fifo_full = 1'b0;
    idle(45);
    clear_queues();
  endtask

  task automatic test_missing_term;
    clear_queues();
    e_nz.push_back(16'h09F0);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) e_nz.push_back({8'(i + 1), 8'(i)});
      send({8'(i + 1), 8'(i)});
    end
    send(16'hFFFF);
    e_nz.push_back(16'h20F1);
    idle(45);
    n_checks++; if (q_nz.size() != e_nz.size()) begin n_fail++; $display("FAIL noterm_nz_count: got %0d expected %0d", q_nz.size(), e_nz.size()); end
    for (int i = 0; i < e_nz.size() && i < q_nz.size(); i++) begin
      n_checks++; if (q_nz[i] !== e_nz[i]) begin n_fail++; $display("FAIL noterm_nz_word[%0d]: got %h expected %h", i, q_nz[i], e_nz[i]); end
    end
    n_checks++; if (q_sz.size() != e_nz.size()) begin n_fail++; $display("FAIL noterm_sz_count: got %0d expected %0d", q_sz.size(), e_nz.size()); end
    else begin
      n_checks++; if (q_sz[33] !== 16'h20F1) begin n_fail++; $display("FAIL noterm_sz_trailer: got %h expected 20F1", q_sz[33]); end
    end
    n_checks++; if ({proto_err_sz, proto_err_nz} !== 2'b11) begin n_fail++; $display("FAIL noterm_proto_err: got %b expected 11", {proto_err_sz, proto_err_nz}); end
    clear_queues();
    send(16'hFFFF);
    idle(6);
    n_checks++; if (q_sz.size() != 2) begin n_fail++; $display("FAIL noterm_recover_count: got %0d expected 2", q_sz.size()); end
    else begin
      n_checks++; if ({q_sz[0], q_sz[1]} !== 32'h0AF0_00F1) begin n_fail++; $display("FAIL noterm_recover_words: got %h expected 0AF000F1", {q_sz[0], q_sz[1]}); end
    end
  endtask

  task automatic test_reset_mid_event;
    clear_queues();
    fifo_full = 1'b1;
    for (int i = 0; i < 11; i++) send({8'(i + 1), 8'(i)});
    rst = 1'b1;
    idle(1);
    n_checks++;
    if ({out_din_sz, out_wr_en_sz, event_num_sz, drop_cnt_sz, overflow_sz, proto_err_sz} !== 43'd0) begin
      n_fail++; $display("FAIL midrst_sz_outputs: got %h expected 0", {out_din_sz, out_wr_en_sz, event_num_sz, drop_cnt_sz, overflow_sz, proto_err_sz});
    end
    n_checks++; if ({event_num_nz, proto_err_nz} !== 9'd0) begin n_fail++; $display("FAIL midrst_nz_outputs: got %h expected 0", {event_num_nz, proto_err_nz}); end
    idle(2);
    rst = 1'b0;
    fifo_full = 1'b0;
    idle(10);
    n_checks++; if (q_sz.size() + q_nz.size() != 0) begin n_fail++; $display("FAIL midrst_buffer_empty: got %0d expected 0", q_sz.size() + q_nz.size()); end
    send(16'hFFFF);
    idle(6);
    n_checks++; if (q_nz.size() != 2) begin n_fail++; $display("FAIL midrst_next_count: got %0d expected 2", q_nz.size()); end
    else begin
      n_checks++; if (q_nz[0] !== 16'h00F0) begin n_fail++; $display("FAIL midrst_next_header: got %h expected 00F0", q_nz[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_no_suppress();
    test_backpressure();
    test_drop();
    test_clr_flags();
    test_missing_term();
    test_reset_mid_event();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
